// File: rtl/ann_seq_pkg.sv
// Shared types and defaults for the ANN frame sequencer.
// The state encoding is exported on the debug port, so it is fixed here.
package ann_seq_pkg;

    localparam int DEF_N_IN    = 30;
    localparam int DEF_N_OUT   = 3;
    localparam int DEF_DW      = 10;
    localparam int CLASS_W     = 2;
    localparam int FRAME_CNT_W = 10;

    typedef enum logic [2:0] {
        S_LOAD     = 3'd0,
        S_START    = 3'd1,
        S_WAIT     = 3'd2,
        S_CLASSIFY = 3'd3,
        S_HOLD     = 3'd4
    } state_e;

endpackage

// File: rtl/ann_argmax.sv
// Unsigned argmax over a packed vector of N words.
// A later word must be strictly larger to win, so ties go to the lowest index.
module ann_argmax
    import ann_seq_pkg::*;
#(
    parameter int N  = DEF_N_OUT,
    parameter int DW = DEF_DW,
    parameter int IW = CLASS_W
) (
    input  logic [N*DW-1:0] vec_i,
    output logic [IW-1:0]   idx_o,
    output logic [DW-1:0]   max_o
);

    always_comb begin
        idx_o = '0;
        max_o = vec_i[DW-1:0];
        for (int j = 1; j < N; j++) begin
            if (vec_i[j*DW +: DW] > max_o) begin
                idx_o = IW'(j);
                max_o = vec_i[j*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/ann_frame_sequencer.sv
// Frame sequencer for the drowsiness ANN core: buffers a serial feature
// frame, runs the core with a timeout, and reports the argmax class.
module ann_frame_sequencer
    import ann_seq_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_OUT   = DEF_N_OUT,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 4096
) (
    input  logic                   Clock,
    input  logic                   Rst,
    input  logic                   feat_valid,
    input  logic [DW-1:0]          feat_data,
    input  logic                   feat_last,
    output logic                   feat_ready,
    output logic [N_IN*DW-1:0]     ann_in,
    output logic                   ann_start,
    input  logic                   ann_done,
    input  logic [N_OUT*DW-1:0]    ann_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CLASS_W-1:0]     res_class,
    output logic [DW-1:0]          res_score,
    output logic                   err_len,
    output logic                   err_timeout,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [2:0]             state
);

    localparam int IDX_W = $clog2(N_IN);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_IN*DW-1:0]       fbuf_q, fbuf_d;
    logic [N_OUT*DW-1:0]      cap_q, cap_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ann_start_q, ann_start_d;
    logic                     res_valid_q, res_valid_d;
    logic [CLASS_W-1:0]       res_class_q, res_class_d;
    logic [DW-1:0]            res_score_q, res_score_d;
    logic                     err_len_q, err_len_d;
    logic                     err_timeout_q, err_timeout_d;
    logic [FRAME_CNT_W-1:0]   frame_count_q, frame_count_d;

    logic                     beat_acc;
    logic [CLASS_W-1:0]       am_idx;
    logic [DW-1:0]            am_max;

    ann_argmax #(
        .N  (N_OUT),
        .DW (DW),
        .IW (CLASS_W)
    ) u_argmax (
        .vec_i (cap_q),
        .idx_o (am_idx),
        .max_o (am_max)
    );

    assign feat_ready = (state_q == S_LOAD);
    assign beat_acc   = feat_valid && feat_ready;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        fbuf_d        = fbuf_q;
        cap_d         = cap_q;
        cnt_d         = cnt_q;
        ann_start_d   = 1'b0;
        res_valid_d   = res_valid_q;
        res_class_d   = res_class_q;
        res_score_d   = res_score_q;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            S_LOAD: begin
                if (beat_acc) begin
                    fbuf_d[idx_q*DW +: DW] = feat_data;
                    if (idx_q == IDX_LAST && feat_last) begin
                        idx_d       = '0;
                        ann_start_d = 1'b1;
                        state_d     = S_START;
                    end else if (feat_last || idx_q == IDX_LAST) begin
                        // wrong-length frame: drop it and resync on the next beat
                        idx_d     = '0;
                        err_len_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ann_done) begin
                    cap_d   = ann_out;
                    state_d = S_CLASSIFY;
                end else if (cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    idx_d         = '0;
                    state_d       = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLASSIFY: begin
                res_class_d = am_idx;
                res_score_d = am_max;
                res_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d   = 1'b0;
                    frame_count_d = frame_count_q + 1'b1;
                    idx_d         = '0;
                    state_d       = S_LOAD;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q       <= S_LOAD;
            idx_q         <= '0;
            fbuf_q        <= '0;
            cap_q         <= '0;
            cnt_q         <= '0;
            ann_start_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_class_q   <= '0;
            res_score_q   <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            fbuf_q        <= fbuf_d;
            cap_q         <= cap_d;
            cnt_q         <= cnt_d;
            ann_start_q   <= ann_start_d;
            res_valid_q   <= res_valid_d;
            res_class_q   <= res_class_d;
            res_score_q   <= res_score_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign ann_in      = fbuf_q;
    assign ann_start   = ann_start_q;
    assign res_valid   = res_valid_q;
    assign res_class   = res_class_q;
    assign res_score   = res_score_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign frame_count = frame_count_q;
    assign state       = state_q;

endmodule
